crossing_request: RTL and testbench

// Pedestrian-crossing front end that feeds the traffic-light controller's stop input.
// It synchronises and debounces a raw push-button and waits until the light is not showing yellow.
// It then holds stop high for a fixed walk plus clearance interval, drives walk/dont_walk lamps,
// and enforces a hold-off before the next crossing. It sits directly upstream of the light: stop -> light.stop.

---
 rtl/crossing_request_if.sv | 28 ++
 rtl/crossing_request.sv | 146 ++++++++++++++
 tb/tb_crossing_request.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/crossing_request_if.sv
// Pedestrian-crossing signal bundle between the button/light side and the crossing front end.
// The master drives the button and yellow lamp inputs. The slave (crossing_request) drives the lamps and the stop request.
interface crossing_request_if;
  logic button;
  logic yellow;
  logic stop;
  logic walk;
  logic dont_walk;
  logic pending;

  modport master (
    output button,
    output yellow,
    input  stop,
    input  walk,
    input  dont_walk,
    input  pending
  );

  modport slave (
    input  button,
    input  yellow,
    output stop,
    output walk,
    output dont_walk,
    output pending
  );
endinterface

// File: rtl/crossing_request.sv
// Pedestrian-crossing front end: syncs and debounces the button, waits out yellow,
// holds stop for walk + clearance, then enforces a hold-off before the next crossing.
module crossing_request #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 15,
  parameter int CLEAR_CYCLES    = 5,
  parameter int HOLDOFF_CYCLES  = 30,
  parameter int CNT_W           = 6
) (
  input  logic              clk,
  input  logic              rst,
  crossing_request_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LAST    = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WALK,
    ST_CLEAR,
    ST_HOLDOFF
  } state_t;

  logic             s1, s2;
  logic             deb;
  logic [CNT_W-1:0] dcnt;
  logic [1:0]       warm;
  logic             armed;
  logic             deb_next;
  logic             press;

  state_t           state, state_d;
  logic [CNT_W-1:0] pcnt, pcnt_d;
  logic             req, req_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      dcnt  <= '0;
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      s1   <= bus.button;
      s2   <= s1;
      warm <= {warm[0], 1'b1};
      // A button held through reset must be seen released before it may start a crossing.
      if (warm[1] && !s2) armed <= 1'b1;
      if (s2 == deb) begin
        dcnt <= '0;
      end else if (dcnt == DEB_LAST) begin
        deb  <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + CNT_W'(1);
      end
    end
  end

  // press fires on the edge that commits the new debounced level, saving a cycle of latency.
  assign deb_next = ((s2 != deb) && (dcnt == DEB_LAST)) ? s2 : deb;
  assign press    = deb_next & ~deb & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pcnt  <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_d;
      pcnt  <= pcnt_d;
      req   <= req_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    pcnt_d  = pcnt + CNT_W'(1);
    req_d   = req;
    unique case (state)
      ST_IDLE: begin
        pcnt_d = '0;
        if (press) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        pcnt_d = '0;
        if (!bus.yellow) state_d = ST_WALK;
      end
      ST_WALK: begin
        if (pcnt == WALK_LAST) begin
          state_d = ST_CLEAR;
          pcnt_d  = '0;
        end
      end
      ST_CLEAR: begin
        if (pcnt == CLEAR_LAST) begin
          state_d = ST_HOLDOFF;
          pcnt_d  = '0;
        end
      end
      ST_HOLDOFF: begin
        if (press) req_d = 1'b1;
        if (pcnt == HOLDOFF_LAST) begin
          state_d = (req || press) ? ST_WAIT : ST_IDLE;
          pcnt_d  = '0;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.stop      = 1'b0;
    bus.walk      = 1'b0;
    bus.dont_walk = 1'b1;
    bus.pending   = 1'b0;
    unique case (state)
      ST_IDLE: ;
      ST_WAIT: bus.pending = 1'b1;
      ST_WALK: begin
        bus.stop      = 1'b1;
        bus.walk      = 1'b1;
        bus.dont_walk = 1'b0;
      end
      ST_CLEAR: begin
        bus.stop      = 1'b1;
        bus.dont_walk = ~pcnt[0];
      end
      ST_HOLDOFF: bus.pending = req;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crossing_request.sv
// Directed bench for crossing_request: default timing instance plus a minimum-count instance.
// Inputs change 1 ns after the rising edge; outputs are checked at that point.
module tb_crossing_request;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  crossing_request_if bus_a ();
  crossing_request_if bus_b ();

  crossing_request dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  crossing_request #(
    .DEBOUNCE_CYCLES (1),
    .WALK_CYCLES     (1),
    .CLEAR_CYCLES    (1),
    .HOLDOFF_CYCLES  (1),
    .CNT_W           (2)
  ) dut_min (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic s, input logic w, input logic d, input logic p);
    chk({tag, ".stop"},      bus_a.stop,      s);
    chk({tag, ".walk"},      bus_a.walk,      w);
    chk({tag, ".dont_walk"}, bus_a.dont_walk, d);
    chk({tag, ".pending"},   bus_a.pending,   p);
  endtask

  task automatic chk_b(input string tag, input logic s, input logic w, input logic d, input logic p);
    chk({tag, ".stop"},      bus_b.stop,      s);
    chk({tag, ".walk"},      bus_b.walk,      w);
    chk({tag, ".dont_walk"}, bus_b.dont_walk, d);
    chk({tag, ".pending"},   bus_b.pending,   p);
  endtask

  initial begin
    bus_a.button = 1'b0;
    bus_a.yellow = 1'b0;
    bus_b.button = 1'b0;
    bus_b.yellow = 1'b0;

    // Reset state
    step(2);
    rst = 1'b0;
    chk_a("reset_a", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_b("reset_b", 1'b0, 1'b0, 1'b1, 1'b0);
    step(4);

    // 1: held press, full crossing timing
    bus_a.button = 1'b1;
    step(6);
    chk_a("t1_wait", 1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    chk_a("t1_walk_first", 1'b1, 1'b1, 1'b0, 1'b0);
    step(14);
    chk_a("t1_walk_last", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk_a("t1_clear", 1'b1, 1'b0, logic'(k % 2), 1'b0);
    end
    step(1);
    chk_a("t1_holdoff", 1'b0, 1'b0, 1'b1, 1'b0);
    bus_a.button = 1'b0;
    step(29);
    chk_a("t1_holdoff_end", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_a("t1_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    step(10);

    // 2: bounce shorter than the debounce window
    for (int i = 0; i < 4; i++) begin
      bus_a.button = (i % 2 == 0);
      step(1);
    end
    bus_a.button = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk_a("t2_bounce", 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // 3: press while yellow is showing
    bus_a.yellow = 1'b1;
    bus_a.button = 1'b1;
    step(6);
    chk_a("t3_wait", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_a("t3_yellow", 1'b0, 1'b0, 1'b1, 1'b1);
    end
    bus_a.yellow = 1'b0;
    step(1);
    chk_a("t3_walk", 1'b1, 1'b1, 1'b0, 1'b0);

    // 4a: re-press during WALK is ignored
    bus_a.button = 1'b0;
    step(7);
    bus_a.button = 1'b1;
    step(12);
    chk_a("t4_clear_end", 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_a("t4_walk_press_ignored", 1'b0, 1'b0, 1'b1, 1'b0);

    // 4b: press during HOLDOFF is latched and served afterwards
    bus_a.button = 1'b0;
    step(6);
    bus_a.button = 1'b1;
    step(5);
    chk_a("t4_before_req", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_a("t4_req", 1'b0, 1'b0, 1'b1, 1'b1);
    bus_a.button = 1'b0;
    step(17);
    chk_a("t4_req_hold", 1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    chk_a("t4_wait", 1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    chk_a("t4_walk", 1'b1, 1'b1, 1'b0, 1'b0);
    step(19);
    chk_a("t4_clear5", 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_a("t4_holdoff", 1'b0, 1'b0, 1'b1, 1'b0);
    step(30);
    chk_a("t4_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    step(5);
    chk_a("t4_single", 1'b0, 1'b0, 1'b1, 1'b0);

    // 5: reset mid-WALK with the button held
    bus_a.button = 1'b1;
    step(7);
    chk_a("t5_walk", 1'b1, 1'b1, 1'b0, 1'b0);
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_a("t5_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_a("t5_held", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    bus_a.button = 1'b0;
    step(8);
    bus_a.button = 1'b1;
    step(6);
    chk_a("t5_repress_wait", 1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    chk_a("t5_repress_walk", 1'b1, 1'b1, 1'b0, 1'b0);

    // 6: all counts at 1
    bus_b.button = 1'b1;
    step(3);
    chk_b("t6_wait", 1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    chk_b("t6_walk", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_b("t6_clear", 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_b("t6_holdoff", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_b("t6_idle", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
